// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding valid/ready slave in front of a
// word-organised RAM with byte-lane writes and programmable wait states.
module dmem_responder #(
    parameter int          DATAWIDTH   = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic                   DMEM_Clk_In,
    input  logic                   DMEM_Reset_In,
    input  logic                   DMEM_Valid_In,
    input  logic                   DMEM_Write_In,
    input  logic [31:0]            DMEM_Addr_InBUS,
    input  logic [DATAWIDTH/8-1:0] DMEM_Byteenable_InBUS,
    input  logic [DATAWIDTH-1:0]   DMEM_Writedata_InBUS,
    input  logic                   DMEM_Ready_In,
    output logic                   DMEM_Ready_Out,
    output logic                   DMEM_Valid_Out,
    output logic [DATAWIDTH-1:0]   DMEM_Readdata_OutBUS,
    output logic                   DMEM_Error_Out
);

    localparam int          NB     = DATAWIDTH / 8;
    localparam int          ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WS     = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [31:0]            addr_q, addr_d;
    logic [NB-1:0]          be_q, be_d;
    logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
    logic                   write_q, write_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic [DATAWIDTH-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [DATAWIDTH-1:0]   mem_q [DEPTH_WORDS];

    logic [31:0]            off;
    logic                   in_range;
    logic [ADDR_W-1:0]      idx;
    logic                   access;
    logic                   mem_we;

    // Unsigned subtract: addresses below BASE wrap high and fall out of range.
    assign off      = addr_q - BASE_ADDR;
    assign in_range = ({1'b0, off} < SPAN);
    assign idx      = off[ADDR_W+1:2];
    assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we   = access && write_q && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        write_d = write_q;
        ready_d = ready_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (DMEM_Valid_In && ready_q) begin
                    addr_d  = DMEM_Addr_InBUS;
                    be_d    = DMEM_Byteenable_InBUS;
                    wdata_d = DMEM_Writedata_InBUS;
                    write_d = DMEM_Write_In;
                    ready_d = 1'b0;
                    cnt_d   = WS;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    valid_d = 1'b1;
                    err_d   = !in_range;
                    rdata_d = (write_q || !in_range) ? '0 : mem_q[idx];
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (valid_q && DMEM_Ready_In) begin
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge DMEM_Clk_In or negedge DMEM_Reset_In) begin
        if (!DMEM_Reset_In) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset; only the access edge may write.
    always_ff @(posedge DMEM_Clk_In) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign DMEM_Ready_Out       = ready_q;
    assign DMEM_Valid_Out       = valid_q;
    assign DMEM_Readdata_OutBUS = rdata_q;
    assign DMEM_Error_Out       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps plus randomized traffic checked
// against a word-map reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, valid_in0, write_in, ready_in;
    logic [31:0] addr_in, wdata_in;
    logic [3:0]  be_in;

    logic        ready1, valid1, err1;
    logic [31:0] rdata1;
    logic        ready0, valid0, err0;
    logic [31:0] rdata0;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [int];

    always #5 clk = ~clk;

    dmem_responder #(
        .DATAWIDTH(32), .DEPTH_WORDS(1024),
        .BASE_ADDR(32'h0), .WAIT_STATES(1)
    ) dut (
        .DMEM_Clk_In(clk), .DMEM_Reset_In(rst_n),
        .DMEM_Valid_In(valid_in), .DMEM_Write_In(write_in),
        .DMEM_Addr_InBUS(addr_in), .DMEM_Byteenable_InBUS(be_in),
        .DMEM_Writedata_InBUS(wdata_in), .DMEM_Ready_In(ready_in),
        .DMEM_Ready_Out(ready1), .DMEM_Valid_Out(valid1),
        .DMEM_Readdata_OutBUS(rdata1), .DMEM_Error_Out(err1)
    );

    dmem_responder #(
        .DATAWIDTH(32), .DEPTH_WORDS(16),
        .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)
    ) dut0 (
        .DMEM_Clk_In(clk), .DMEM_Reset_In(rst_n),
        .DMEM_Valid_In(valid_in0), .DMEM_Write_In(write_in),
        .DMEM_Addr_InBUS(addr_in), .DMEM_Byteenable_InBUS(be_in),
        .DMEM_Writedata_InBUS(wdata_in), .DMEM_Ready_In(ready_in),
        .DMEM_Ready_Out(ready0), .DMEM_Valid_Out(valid0),
        .DMEM_Readdata_OutBUS(rdata0), .DMEM_Error_Out(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Waits for Ready_Out, presents one request, returns at the negedge after accept.
    task automatic issue(input bit use0, input bit wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        while (!(use0 ? ready0 : ready1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(n < 20), 32'd1);
        write_in = wr;
        addr_in  = a;
        be_in    = be;
        wdata_in = wd;
        if (use0) valid_in0 = 1'b1;
        else      valid_in  = 1'b1;
        @(negedge clk);
        valid_in  = 1'b0;
        valid_in0 = 1'b0;
        check("ready_drop", 32'(use0 ? ready0 : ready1), 32'd0);
    endtask

    task automatic await_resp(input bit use0, input int exp_lat);
        int n = 0;
        while (!(use0 ? valid0 : valid1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(exp_lat));
    endtask

    // Holds Ready_In low for 'hold' cycles while poking a stray store, then handshakes.
    task automatic finish_resp(input bit use0, input int hold,
                               output logic [31:0] rd, output logic er);
        rd = use0 ? rdata0 : rdata1;
        er = use0 ? err0 : err1;
        for (int h = 0; h < hold; h++) begin
            write_in = 1'b1;
            addr_in  = 32'h30;
            be_in    = 4'hF;
            wdata_in = 32'hBAD0_BAD0;
            if (use0) valid_in0 = 1'b1;
            else      valid_in  = 1'b1;
            @(negedge clk);
            check("hold_valid", 32'(use0 ? valid0 : valid1), 32'd1);
            check("hold_rdata", use0 ? rdata0 : rdata1, rd);
            check("hold_ready", 32'(use0 ? ready0 : ready1), 32'd0);
        end
        valid_in  = 1'b0;
        valid_in0 = 1'b0;
        ready_in  = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        check("hs_valid", 32'(use0 ? valid0 : valid1), 32'd0);
        check("hs_ready", 32'(use0 ? ready0 : ready1), 32'd1);
        check("hs_rdata_hold", use0 ? rdata0 : rdata1, rd);
    endtask

    task automatic do_req(input bit use0, input bit wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          input int hold, output logic [31:0] rd,
                          output logic er);
        issue(use0, wr, a, be, wd);
        await_resp(use0, use0 ? 1 : 2);
        finish_resp(use0, hold, rd, er);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a, wd, expd;
        logic [3:0]  be;
        int          op;

        rst_n = 1'b0;
        valid_in = 1'b0; valid_in0 = 1'b0; write_in = 1'b0;
        ready_in = 1'b0; addr_in = '0; be_in = '0; wdata_in = '0;

        #2;
        check("rst_ready", 32'(ready1), 32'd0);
        check("rst_valid", 32'(valid1), 32'd0);
        check("rst_rdata", rdata1, 32'd0);
        check("rst_err", 32'(err1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready_before_edge", 32'(ready1), 32'd0);
        @(negedge clk);
        check("rel_ready", 32'(ready1), 32'd1);
        check("rel_ready0", 32'(ready0), 32'd1);
        check("rel_valid", 32'(valid1), 32'd0);

        do_req(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, rd, er);
        check("st_rdata", rd, 32'd0);
        check("st_err", 32'(er), 32'd0);
        do_req(0, 0, 32'h10, 4'h0, 32'h0, 0, rd, er);
        check("ld_full", rd, 32'hDEADBEEF);
        check("ld_err", 32'(er), 32'd0);

        do_req(0, 1, 32'h10, 4'b0010, 32'h0000_5500, 0, rd, er);
        do_req(0, 0, 32'h10, 4'h0, 32'h0, 0, rd, er);
        check("ld_lane1", rd, 32'hDEAD55EF);
        do_req(0, 1, 32'h13, 4'b0000, 32'h1234_5678, 0, rd, er);
        check("be0_err", 32'(er), 32'd0);
        do_req(0, 0, 32'h12, 4'h0, 32'h0, 0, rd, er);
        check("ld_be0", rd, 32'hDEAD55EF);

        do_req(0, 1, 32'h30, 4'hF, 32'h3030_3030, 0, rd, er);
        do_req(0, 0, 32'h10, 4'h0, 32'h0, 5, rd, er);
        check("hold_ld", rd, 32'hDEAD55EF);
        do_req(0, 0, 32'h30, 4'h0, 32'h0, 0, rd, er);
        check("stray_ignored", rd, 32'h3030_3030);

        do_req(0, 1, 32'h0, 4'hF, 32'hA5A5_0000, 0, rd, er);
        do_req(0, 1, 32'hFFC, 4'hF, 32'h0FFC_0FFC, 0, rd, er);
        check("last_st_err", 32'(er), 32'd0);
        do_req(0, 0, 32'h1000, 4'h0, 32'h0, 0, rd, er);
        check("oor_ld_err", 32'(er), 32'd1);
        check("oor_ld_rdata", rd, 32'd0);
        do_req(0, 1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 2, rd, er);
        check("oor_st_err", 32'(er), 32'd1);
        do_req(0, 0, 32'h0, 4'h0, 32'h0, 0, rd, er);
        check("oor_no_alias", rd, 32'hA5A5_0000);
        do_req(0, 0, 32'hFFC, 4'h0, 32'h0, 0, rd, er);
        check("last_word", rd, 32'h0FFC_0FFC);
        check("last_err", 32'(er), 32'd0);

        do_req(0, 1, 32'h20, 4'hF, 32'h1111_1111, 0, rd, er);
        do_req(0, 0, 32'h20, 4'h0, 32'h0, 0, rd, er);
        issue(0, 1, 32'h20, 4'hF, 32'h2222_2222);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready1), 32'd0);
        check("midrst_rdata", rdata1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_back", 32'(ready1), 32'd1);
        do_req(0, 0, 32'h20, 4'h0, 32'h0, 0, rd, er);
        check("store_discarded", rd, 32'h1111_1111);

        issue(0, 0, 32'h20, 4'h0, 32'h0);
        await_resp(0, 2);
        check("resp_valid", 32'(valid1), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_valid_drop", 32'(valid1), 32'd0);
        check("async_rdata_clr", rdata1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(0, 0, 32'h10, 4'h0, 32'h0, 0, rd, er);
        check("after_rst_keep", rd, 32'hDEAD55EF);

        do_req(1, 1, 32'h1004, 4'hF, 32'hCAFE_F00D, 0, rd, er);
        do_req(1, 0, 32'h1004, 4'h0, 32'h0, 1, rd, er);
        check("ws0_ld", rd, 32'hCAFE_F00D);
        do_req(1, 0, 32'h0FFC, 4'h0, 32'h0, 0, rd, er);
        check("below_base_err", 32'(er), 32'd1);
        check("below_base_rdata", rd, 32'd0);
        do_req(1, 0, 32'h1040, 4'h0, 32'h0, 0, rd, er);
        check("above_top_err", 32'(er), 32'd1);
        do_req(1, 1, 32'h103C, 4'hF, 32'h0000_003C, 0, rd, er);
        check("top_word_err", 32'(er), 32'd0);

        for (int k = 0; k < 8; k++) begin
            a  = 32'h200 + 32'(4 * k);
            wd = $urandom;
            model[int'(a)] = wd;
            do_req(0, 1, a, 4'hF, wd, 0, rd, er);
        end
        for (int t = 0; t < 40; t++) begin
            op = $urandom_range(0, 3);
            be = 4'($urandom);
            wd = $urandom;
            if (op == 0) begin
                a = 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
                do_req(0, 1'($urandom), a, be, wd, $urandom_range(0, 3), rd, er);
                check("rnd_oor_err", 32'(er), 32'd1);
                check("rnd_oor_rdata", rd, 32'd0);
            end else begin
                a = 32'h200 + 32'(4 * $urandom_range(0, 7));
                if (op == 1) begin
                    model[int'(a)] = merge(model[int'(a)], be, wd);
                    do_req(0, 1, a + 32'($urandom_range(0, 3)), be, wd,
                           $urandom_range(0, 3), rd, er);
                    check("rnd_st_rdata", rd, 32'd0);
                end else begin
                    expd = model[int'(a)];
                    do_req(0, 0, a + 32'($urandom_range(0, 3)), be, wd,
                           $urandom_range(0, 3), rd, er);
                    check("rnd_ld", rd, expd);
                end
                check("rnd_err", 32'(er), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
